// File: rtl/rvs192_cache_pkg.sv
// Shared L1 cache definitions: miss-handler state encoding, address-field widths, field extraction.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rvs192_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        COMMIT,
        FLUSH
    } refill_state_t;

    // Field widths for a byte address split as {tag, index, word, byte[1:0]}.
    function automatic int calc_off_w(input int beats);
        return $clog2(beats);
    endfunction

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int lines, input int beats);
        return addr_w - $clog2(lines) - $clog2(beats) - 2;
    endfunction

    // Extractors return a wide value; callers size-cast down to the field width.
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w, input int off_w);
        return (addr >> (off_w + 2)) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w, input int off_w);
        return addr >> (idx_w + off_w + 2);
    endfunction

endpackage

// File: rtl/l1_refill_ctrl.sv
// L1 miss handler: invalidates the victim, fetches a line from L2 into the data array, writes tag then sets valid; also walks a full flush.
// Latency: victim clear same cycle as the miss; valid set 1 + ack wait + BEATS beats + 1 cycles later; flush takes CACHE_LINE cycles plus the done pulse.
// Backpressure: holds the pipeline via stall; mem_req/mem_addr held until mem_ack; fill beats advance only on mem_rvalid.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cpu_req, cpu_addr          lookup valid and byte address
//   hit_valid, tag_match       valid-array bit and tag comparator result for the lookup
//   stall                      pipeline hold
//   valid_read_index           index field of cpu_addr (combinational)
//   valid_write_index, valid_set, valid_clear   valid-array write side
//   flush_req, flush_done      invalidate-all request (level) and completion pulse
//   mem_req, mem_addr, mem_ack L2 line request handshake
//   mem_rvalid, mem_rdata      L2 read beats
//   fill_we, fill_index, fill_word, fill_data   data-array word write
//   tag_we, tag_data           tag-array write
module l1_refill_ctrl
    import rvs192_cache_pkg::*;
#(
    parameter  int CACHE_LINE = 128,
    parameter  int BEATS      = 4,
    parameter  int ADDR_W     = 32,
    localparam int IDX_W      = calc_idx_w(CACHE_LINE),
    localparam int OFF_W      = calc_off_w(BEATS),
    localparam int TAG_W      = calc_tag_w(ADDR_W, CACHE_LINE, BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              hit_valid,
    input  logic              tag_match,
    output logic              stall,
    output logic [IDX_W-1:0]  valid_read_index,
    output logic [IDX_W-1:0]  valid_write_index,
    output logic              valid_set,
    output logic              valid_clear,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              fill_we,
    output logic [IDX_W-1:0]  fill_index,
    output logic [OFF_W-1:0]  fill_word,
    output logic [31:0]       fill_data,
    output logic              tag_we,
    output logic [TAG_W-1:0]  tag_data
);

    refill_state_t    state;
    logic [IDX_W-1:0] cnt;          // beat counter during FILL, index walker during FLUSH
    logic [IDX_W-1:0] lat_idx;
    logic [TAG_W-1:0] lat_tag;
    logic             flush_pending;
    logic             done_q;

    logic [IDX_W-1:0] cur_idx;
    logic [TAG_W-1:0] cur_tag;
    logic             miss;
    logic             flush_any;
    logic             idle_miss;

    assign cur_idx          = IDX_W'(addr_index(64'(cpu_addr), IDX_W, OFF_W));
    assign cur_tag          = TAG_W'(addr_tag(64'(cpu_addr), IDX_W, OFF_W));
    assign valid_read_index = cur_idx;

    assign miss      = cpu_req & ~(hit_valid & tag_match);
    assign flush_any = flush_req | flush_pending;
    // Flush wins over a miss in IDLE, so the victim clear is suppressed then.
    // Gated by rst_n so the outputs are quiet while reset is held.
    assign idle_miss = rst_n & (state == IDLE) & miss & ~flush_any;

    assign stall      = rst_n & ((state != IDLE) | miss | flush_any);
    assign flush_done = done_q;

    always_comb begin
        valid_write_index = '0;
        valid_set         = 1'b0;
        valid_clear       = 1'b0;
        mem_req           = 1'b0;
        mem_addr          = '0;
        fill_we           = 1'b0;
        fill_index        = '0;
        fill_word         = '0;
        fill_data         = '0;
        tag_we            = 1'b0;
        tag_data          = '0;
        case (state)
            IDLE: begin
                if (idle_miss) begin
                    valid_clear       = 1'b1;
                    valid_write_index = cur_idx;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = {lat_tag, lat_idx, {(OFF_W + 2){1'b0}}};
            end
            FILL: begin
                if (mem_rvalid) begin
                    fill_we    = 1'b1;
                    fill_index = lat_idx;
                    fill_word  = cnt[OFF_W-1:0];
                    fill_data  = mem_rdata;
                end
            end
            COMMIT: begin
                // Tag and valid land together, after every data word is written.
                tag_we            = 1'b1;
                tag_data          = lat_tag;
                valid_set         = 1'b1;
                valid_write_index = lat_idx;
            end
            FLUSH: begin
                valid_clear       = 1'b1;
                valid_write_index = cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_idx       <= '0;
            lat_tag       <= '0;
            flush_pending <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_any) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end else if (miss) begin
                        lat_idx <= cur_idx;
                        lat_tag <= cur_tag;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (flush_req) flush_pending <= 1'b1;
                    if (mem_ack) begin
                        state <= FILL;
                        cnt   <= '0;
                    end
                end
                FILL: begin
                    if (flush_req) flush_pending <= 1'b1;
                    if (mem_rvalid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt[OFF_W-1:0] == OFF_W'(BEATS - 1)) state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (flush_req) flush_pending <= 1'b1;
                    state <= IDLE;
                end
                FLUSH: begin
                    // A held flush_req here belongs to the flush already running.
                    if (cnt == IDX_W'(CACHE_LINE - 1)) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        flush_pending <= 1'b0;
                        done_q        <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Self-checking bench for l1_refill_ctrl: miss/fill, hits, conflict miss, flush, flush during fill, rvalid gaps and mid-fill reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_l1_refill_ctrl;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 7;
    localparam int OFF_W  = 2;
    localparam int TAG_W  = 21;

    localparam logic [2:0] EV_REQ  = 3'd1;
    localparam logic [2:0] EV_FILL = 3'd2;
    localparam logic [2:0] EV_TAG  = 3'd3;
    localparam logic [2:0] EV_SET  = 3'd4;
    localparam logic [2:0] EV_CLR  = 3'd5;
    localparam logic [2:0] EV_DONE = 3'd6;

    logic              clk;
    logic              rst_n;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              hit_valid;
    logic              tag_match;
    logic              stall;
    logic [IDX_W-1:0]  valid_read_index;
    logic [IDX_W-1:0]  valid_write_index;
    logic              valid_set;
    logic              valid_clear;
    logic              flush_req;
    logic              flush_done;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              fill_we;
    logic [IDX_W-1:0]  fill_index;
    logic [OFF_W-1:0]  fill_word;
    logic [31:0]       fill_data;
    logic              tag_we;
    logic [TAG_W-1:0]  tag_data;

    l1_refill_ctrl #(.CACHE_LINE(128), .BEATS(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .hit_valid(hit_valid), .tag_match(tag_match),
        .stall(stall), .valid_read_index(valid_read_index), .valid_write_index(valid_write_index),
        .valid_set(valid_set), .valid_clear(valid_clear),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_index(fill_index), .fill_word(fill_word), .fill_data(fill_data),
        .tag_we(tag_we), .tag_data(tag_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int clr_cyc = 0;
    int set_cyc = 0;
    logic mem_req_d = 1'b0;

    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [2:0]  kind;
        logic [47:0] dat;
    } ev_t;

    ev_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic expect_ev(input logic [2:0] k, input logic [47:0] d);
        ev_t e;
        e.kind = k;
        e.dat  = d;
        exp_q.push_back(e);
    endtask

    task automatic see(input string tag, input logic [2:0] k, input logic [47:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk({"unexpected ", tag}, {13'b0, k, d}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {13'b0, k, d}, {13'b0, e.kind, e.dat});
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_req && !mem_req_d) see("mem_req", EV_REQ, 48'(mem_addr));
        mem_req_d = mem_req;
        if (fill_we) see("fill", EV_FILL, {7'b0, fill_index, fill_word, fill_data});
        if (tag_we) see("tag", EV_TAG, 48'(tag_data));
        if (valid_set) begin
            see("set", EV_SET, 48'(valid_write_index));
            set_cyc = cyc;
        end
        if (valid_clear) begin
            see("clear", EV_CLR, 48'(valid_write_index));
            clr_cyc = cyc;
        end
        if (flush_done) see("flush_done", EV_DONE, 48'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_flush();
        for (int i = 0; i < 128; i++) expect_ev(EV_CLR, 48'(i));
        expect_ev(EV_DONE, 48'd0);
    endtask

    // Walks the flush from its first FLUSH cycle through the done pulse.
    task automatic run_flush_walk();
        repeat (128) tick();
        chk("flush_done_pulse", 64'(flush_done), 64'd1);
        chk("flush_done_stall", 64'(stall), 64'd0);
        tick();
        chk("flush_done_once", 64'(flush_done), 64'd0);
    endtask

    // One full miss. flush_after >= 0 raises flush_req for one cycle after that beat.
    task automatic run_miss(input logic [31:0] a, input logic hv, input int ack_dly, input int gap,
                            input logic [31:0] dbase, input int flush_after, output int clr2set);
        logic [6:0]  ix;
        logic [20:0] tg;
        ix = a[10:4];
        tg = a[31:11];
        clr2set = 0;
        expect_ev(EV_CLR, 48'(ix));
        expect_ev(EV_REQ, 48'(a & 32'hFFFF_FFF0));
        for (int b = 0; b < 4; b++) expect_ev(EV_FILL, {7'b0, ix, 2'(b), dbase + 32'(b)});
        expect_ev(EV_TAG, 48'(tg));
        expect_ev(EV_SET, 48'(ix));
        if (flush_after >= 0) expect_flush();

        cpu_req = 1'b1; cpu_addr = a; hit_valid = hv; tag_match = 1'b0;
        #1 chk("miss_stall", 64'(stall), 64'd1);
        tick();
        // Beats offered before the ack must be ignored.
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        repeat (ack_dly) tick();
        mem_ack = 1'b1;
        #1 chk("req_addr_hold", 64'(mem_addr), 64'(a & 32'hFFFF_FFF0));
        tick();
        mem_ack = 1'b0; mem_rvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            repeat (gap) tick();
            mem_rvalid = 1'b1; mem_rdata = dbase + 32'(b);
            tick();
            mem_rvalid = 1'b0;
            if (b == flush_after) begin
                flush_req = 1'b1;
                tick();
                flush_req = 1'b0;
            end
        end
        #1 chk("commit_stall", 64'(stall), 64'd1);
        tick();
        if (flush_after < 0) begin
            hit_valid = 1'b1; tag_match = 1'b1;
            #1 chk("retry_hit_stall", 64'(stall), 64'd0);
            clr2set = set_cyc - clr_cyc;
            tick();
            cpu_req = 1'b0; hit_valid = 1'b0; tag_match = 1'b0;
        end else begin
            // Pending flush outranks the still-missing lookup.
            #1 chk("pending_flush_stall", 64'(stall), 64'd1);
            chk("pending_no_miss_clear", 64'(valid_clear), 64'd0);
            tick();
            cpu_req = 1'b0; hit_valid = 1'b0;
            run_flush_walk();
        end
    endtask

    initial begin
        int d;
        logic [31:0] ra;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0000_0A50; hit_valid = 1'b0; tag_match = 1'b0;
        flush_req = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_outs", {49'b0, stall, valid_set, valid_clear, flush_done, mem_req, fill_we, tag_we},
            64'd0);
        chk("rst_read_index", 64'(valid_read_index), 64'h25);
        rst_n = 1'b1;
        tick();
        chk("idle_stall", 64'(stall), 64'd0);

        // Cold miss.
        run_miss(32'h0000_1234, 1'b0, 2, 0, 32'hA000_0000, -1, d);
        chk("miss_clr_to_set", 64'(d), 64'(2 + 6));

        // Ten hits.
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            cpu_req = 1'b1; cpu_addr = ra; hit_valid = 1'b1; tag_match = 1'b1;
            #1 chk("hit_stall", 64'(stall), 64'd0);
            chk("hit_quiet", {61'b0, mem_req, valid_set, valid_clear}, 64'd0);
            chk("hit_read_index", 64'(valid_read_index), 64'(ra[10:4]));
            tick();
        end
        cpu_req = 1'b0; hit_valid = 1'b0; tag_match = 1'b0;
        tick();

        // Conflict miss: valid but wrong tag.
        run_miss(32'h0000_9234, 1'b1, 3, 0, 32'hC0DE_0000, -1, d);
        chk("conflict_clr_to_set", 64'(d), 64'(3 + 6));

        // Flush from IDLE.
        expect_flush();
        flush_req = 1'b1;
        #1 chk("flush_req_stall", 64'(stall), 64'd1);
        tick();
        flush_req = 1'b0;
        chk("flushing_stall", 64'(stall), 64'd1);
        run_flush_walk();

        // Flush raised mid-fill.
        run_miss(32'h00AB_C560, 1'b0, 1, 1, 32'h5500_0000, 1, d);

        // rvalid gaps, then reset mid-fill.
        expect_ev(EV_CLR, 48'h44);
        expect_ev(EV_REQ, 48'h0000_4440);
        expect_ev(EV_FILL, {7'b0, 7'h44, 2'd0, 32'h7700_0000});
        expect_ev(EV_FILL, {7'b0, 7'h44, 2'd1, 32'h7700_0001});
        cpu_req = 1'b1; cpu_addr = 32'h0000_4440; hit_valid = 1'b0;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            repeat (3) tick();
            mem_rvalid = 1'b1; mem_rdata = 32'h7700_0000 + 32'(b);
            tick();
            mem_rvalid = 1'b0;
        end
        flush_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {49'b0, stall, valid_set, valid_clear, flush_done, mem_req, fill_we, tag_we},
            64'd0);
        chk("arst_data", {mem_addr, 11'b0, tag_data}, 64'd0);
        chk("arst_fill", {16'b0, fill_index, fill_word, fill_data, valid_write_index}, 64'd0);
        flush_req = 1'b0; cpu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(stall), 64'd0);
        run_miss(32'h0000_4440, 1'b0, 0, 3, 32'h9900_0000, -1, d);

        repeat (3) tick();
        chk("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
